// File: rtl/arp_req_arb.sv
// Shares one ARP request/response channel among S_COUNT requesters, one outstanding transaction at a time.
// Grant held from request accept until response handoff; watchdog turns a lost response into an error and drains the late one.
module arp_req_arb #(
    parameter int              S_COUNT         = 4,
    parameter int              ARB_ROUND_ROBIN = 1,
    parameter longint unsigned TIMEOUT_CYCLES  = 64'd125000000 * 64'd32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [S_COUNT-1:0]                        s_arp_request_valid,
    output logic [S_COUNT-1:0]                        s_arp_request_ready,
    input  logic [32*S_COUNT-1:0]                     s_arp_request_ip,
    output logic [S_COUNT-1:0]                        s_arp_response_valid,
    input  logic [S_COUNT-1:0]                        s_arp_response_ready,
    output logic                                      s_arp_response_error,
    output logic [47:0]                               s_arp_response_mac,
    output logic                                      m_arp_request_valid,
    input  logic                                      m_arp_request_ready,
    output logic [31:0]                               m_arp_request_ip,
    input  logic                                      m_arp_response_valid,
    output logic                                      m_arp_response_ready,
    input  logic                                      m_arp_response_error,
    input  logic [47:0]                               m_arp_response_mac,
    output logic                                      busy,
    output logic [((S_COUNT > 1) ? $clog2(S_COUNT) : 1)-1:0] grant_index,
    output logic                                      timeout_event
);

    localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          drain_q, drain_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]   ip_q, ip_d;
    logic [47:0]   mac_q, mac_d;
    logic          err_q, err_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic          tev_q, tev_d;

    logic          win_vld;
    logic [GW-1:0] win_idx;
    logic [31:0]   win_ip;
    logic          grant_ok;
    logic          expire;
    int            arb_idx;

    // Round-robin searches from last_q+1 with wrap; fixed priority searches from index 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_idx = 0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (ARB_ROUND_ROBIN != 0) begin
                arb_idx = (int'(last_q) + 1 + k) % S_COUNT;
            end else begin
                arb_idx = k;
            end
            if (!win_vld && s_arp_request_valid[arb_idx]) begin
                win_vld = 1'b1;
                win_idx = GW'(arb_idx);
            end
        end
        win_ip = s_arp_request_ip[32*int'(win_idx) +: 32];
    end

    assign grant_ok = (state_q == ST_IDLE) && !drain_q && win_vld;
    assign expire   = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        ip_d    = ip_q;
        mac_d   = mac_q;
        err_d   = err_q;
        grant_d = grant_q;
        last_d  = last_q;
        tev_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    grant_d = win_idx;
                    ip_d    = win_ip;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_arp_request_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the expiry cycle takes precedence over the watchdog.
                if (m_arp_response_valid) begin
                    mac_d   = m_arp_response_mac;
                    err_d   = m_arp_response_error;
                    state_d = ST_RESP;
                end else if (expire) begin
                    mac_d   = '0;
                    err_d   = 1'b1;
                    tev_d   = 1'b1;
                    drain_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (s_arp_response_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
        // Drain never overlaps WAIT, so it can reuse the watchdog counter.
        if (drain_q) begin
            if (m_arp_response_valid || expire) begin
                drain_d = 1'b0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
            cnt_q   <= '0;
            ip_q    <= '0;
            mac_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            last_q  <= GW'(S_COUNT - 1);
            tev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            ip_q    <= ip_d;
            mac_q   <= mac_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tev_q   <= tev_d;
        end
    end

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            s_arp_request_ready[i]  = grant_ok && (win_idx == GW'(i));
            s_arp_response_valid[i] = (state_q == ST_RESP) && (grant_q == GW'(i));
        end
    end

    assign s_arp_response_error = err_q;
    assign s_arp_response_mac   = mac_q;
    assign m_arp_request_valid  = (state_q == ST_REQ);
    assign m_arp_request_ip     = ip_q;
    assign m_arp_response_ready = (state_q == ST_WAIT) || drain_q;
    assign busy                 = (state_q != ST_IDLE) || drain_q;
    assign grant_index          = grant_q;
    assign timeout_event        = tev_q;

endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench for arp_req_arb: round-robin instance (a_*) and fixed-priority instance (b_*) share stimulus.
module tb_arp_req_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_vld = '0;
    logic [127:0] req_ip = '0;
    logic [3:0]   rsp_rdy = '0;
    logic         m_req_rdy = 1'b0;
    logic         m_rsp_vld = 1'b0;
    logic         m_rsp_err = 1'b0;
    logic [47:0]  m_rsp_mac = '0;

    logic [3:0]  a_req_rdy, a_s_rsp_vld, b_req_rdy, b_s_rsp_vld;
    logic        a_err, a_m_req_vld, a_m_rsp_rdy, a_busy, a_tev;
    logic        b_err, b_m_req_vld, b_m_rsp_rdy, b_busy, b_tev;
    logic [47:0] a_mac, b_mac;
    logic [31:0] a_m_req_ip, b_m_req_ip;
    logic [1:0]  a_grant, b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arp_req_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arp_request_valid(req_vld), .s_arp_request_ready(a_req_rdy), .s_arp_request_ip(req_ip),
        .s_arp_response_valid(a_s_rsp_vld), .s_arp_response_ready(rsp_rdy),
        .s_arp_response_error(a_err), .s_arp_response_mac(a_mac),
        .m_arp_request_valid(a_m_req_vld), .m_arp_request_ready(m_req_rdy), .m_arp_request_ip(a_m_req_ip),
        .m_arp_response_valid(m_rsp_vld), .m_arp_response_ready(a_m_rsp_rdy),
        .m_arp_response_error(m_rsp_err), .m_arp_response_mac(m_rsp_mac),
        .busy(a_busy), .grant_index(a_grant), .timeout_event(a_tev));

    arp_req_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .s_arp_request_valid(req_vld), .s_arp_request_ready(b_req_rdy), .s_arp_request_ip(req_ip),
        .s_arp_response_valid(b_s_rsp_vld), .s_arp_response_ready(rsp_rdy),
        .s_arp_response_error(b_err), .s_arp_response_mac(b_mac),
        .m_arp_request_valid(b_m_req_vld), .m_arp_request_ready(m_req_rdy), .m_arp_request_ip(b_m_req_ip),
        .m_arp_response_valid(m_rsp_vld), .m_arp_response_ready(b_m_rsp_rdy),
        .m_arp_response_error(m_rsp_err), .m_arp_response_mac(m_rsp_mac),
        .busy(b_busy), .grant_index(b_grant), .timeout_event(b_tev));

    task automatic do_reset;
        rst_n = 1'b0;
        req_vld = '0; rsp_rdy = '0; m_req_rdy = 1'b0; m_rsp_vld = 1'b0; m_rsp_err = 1'b0; m_rsp_mac = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_m_req_vld, a_m_rsp_rdy, a_tev, a_s_rsp_vld, a_req_rdy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {a_busy, a_m_req_vld, a_m_rsp_rdy, a_tev, a_s_rsp_vld, a_req_rdy});
        end
        checks++;
        if ({a_grant, a_err, a_mac, a_m_req_ip} !== 83'd0) begin
            errors++;
            $display("FAIL reset_data got grant=%0d err=%b mac=%h ip=%h want 0", a_grant, a_err, a_mac, a_m_req_ip);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk);
        req_vld = 4'b0010; req_ip[63:32] = 32'hC0A80102; m_req_rdy = 1'b1; m_rsp_vld = 1'b0; rsp_rdy = '0;
        #1;
        checks++;
        if (a_req_rdy !== 4'b0010) begin errors++; $display("FAIL single_req_rdy got %b want 0010", a_req_rdy); end
        @(negedge clk);
        checks++;
        if ({a_m_req_vld, a_m_req_ip} !== {1'b1, 32'hC0A80102}) begin
            errors++; $display("FAIL single_m_req got vld=%b ip=%h want 1 c0a80102", a_m_req_vld, a_m_req_ip);
        end
        checks++;
        if (a_grant !== 2'd1) begin errors++; $display("FAIL single_grant got %0d want 1", a_grant); end
        req_vld = '0;
        @(negedge clk);
        checks++;
        if ({a_m_req_vld, a_m_rsp_rdy} !== 2'b01) begin
            errors++; $display("FAIL single_wait got req_vld=%b rsp_rdy=%b want 0 1", a_m_req_vld, a_m_rsp_rdy);
        end
        repeat (3) @(negedge clk);
        m_rsp_vld = 1'b1; m_rsp_mac = 48'h001122334455; m_rsp_err = 1'b0;
        @(negedge clk);
        m_rsp_vld = 1'b0;
        checks++;
        if ({a_s_rsp_vld, a_err, a_mac} !== {4'b0010, 1'b0, 48'h001122334455}) begin
            errors++; $display("FAIL single_resp got vld=%b err=%b mac=%h want 0010 0 001122334455", a_s_rsp_vld, a_err, a_mac);
        end
        rsp_rdy = 4'b0010;
        @(negedge clk);
        checks++;
        if ({a_busy, a_s_rsp_vld} !== 5'b0) begin
            errors++; $display("FAIL single_done got busy=%b vld=%b want 0 0000", a_busy, a_s_rsp_vld);
        end
        rsp_rdy = '0;
    endtask

    task automatic test_contention;
        logic [1:0] a_seen [5];
        logic [1:0] b_seen [5];
        logic [3:0] a_oh [5];
        logic [1:0] a_exp [5];
        int na, nb;
        a_exp[0] = 2'd0; a_exp[1] = 2'd1; a_exp[2] = 2'd2; a_exp[3] = 2'd3; a_exp[4] = 2'd0;
        na = 0; nb = 0;
        do_reset();
        req_vld = 4'b1111;
        req_ip = {32'h0A000004, 32'h0A000003, 32'h0A000002, 32'h0A000001};
        m_req_rdy = 1'b1; m_rsp_vld = 1'b1; m_rsp_mac = 48'hDEADBEEF0001; m_rsp_err = 1'b0; rsp_rdy = 4'b1111;
        for (int c = 0; c < 60 && (na < 5 || nb < 5); c++) begin
            @(negedge clk);
            if (a_s_rsp_vld != 4'b0 && na < 5) begin a_seen[na] = a_grant; a_oh[na] = a_s_rsp_vld; na++; end
            if (b_s_rsp_vld != 4'b0 && nb < 5) begin b_seen[nb] = b_grant; nb++; end
        end
        req_vld = '0; m_rsp_vld = 1'b0;
        checks++;
        if (na != 5 || nb != 5) begin
            errors++; $display("FAIL contention_count got rr=%0d fp=%0d want 5 5", na, nb);
        end
        for (int k = 0; k < na; k++) begin
            checks++;
            if (a_seen[k] !== a_exp[k] || a_oh[k] !== (4'b0001 << a_exp[k])) begin
                errors++; $display("FAIL rr_grant[%0d] got %0d/%b want %0d", k, a_seen[k], a_oh[k], a_exp[k]);
            end
        end
        for (int k = 0; k < nb; k++) begin
            checks++;
            if (b_seen[k] !== 2'd0) begin errors++; $display("FAIL fp_grant[%0d] got %0d want 0", k, b_seen[k]); end
        end
        repeat (2) @(negedge clk);
        rsp_rdy = '0;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        req_vld = 4'b0001; m_req_rdy = 1'b1; m_rsp_vld = 1'b0; rsp_rdy = 4'b0001;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        repeat (15) @(negedge clk);
        checks++;
        if ({a_tev, a_s_rsp_vld, a_m_rsp_rdy} !== 6'b000001) begin
            errors++; $display("FAIL timeout_early got tev=%b vld=%b rsp_rdy=%b want 0 0000 1", a_tev, a_s_rsp_vld, a_m_rsp_rdy);
        end
        @(negedge clk);
        checks++;
        if (a_tev !== 1'b1) begin errors++; $display("FAIL timeout_event got %b want 1", a_tev); end
        checks++;
        if ({a_s_rsp_vld, a_err, a_mac} !== {4'b0001, 1'b1, 48'h0}) begin
            errors++; $display("FAIL timeout_resp got vld=%b err=%b mac=%h want 0001 1 0", a_s_rsp_vld, a_err, a_mac);
        end
        req_vld = 4'b0010;
        @(negedge clk);
        checks++;
        if ({a_tev, a_busy, a_m_rsp_rdy, a_req_rdy, a_s_rsp_vld} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
            errors++; $display("FAIL drain_state got tev=%b busy=%b rsp_rdy=%b req_rdy=%b vld=%b want 0 1 1 0000 0000",
                               a_tev, a_busy, a_m_rsp_rdy, a_req_rdy, a_s_rsp_vld);
        end
        @(negedge clk);
        m_rsp_vld = 1'b1; m_rsp_mac = 48'hAABBCCDDEEFF; m_rsp_err = 1'b0;
        checks++;
        if (a_req_rdy !== 4'b0000) begin errors++; $display("FAIL drain_block got req_rdy=%b want 0000", a_req_rdy); end
        @(negedge clk);
        m_rsp_vld = 1'b0;
        checks++;
        if ({a_s_rsp_vld, a_busy, a_req_rdy} !== {4'b0000, 1'b0, 4'b0010}) begin
            errors++; $display("FAIL drain_clear got vld=%b busy=%b req_rdy=%b want 0000 0 0010", a_s_rsp_vld, a_busy, a_req_rdy);
        end
        @(negedge clk);
        checks++;
        if ({a_grant, a_m_req_vld} !== {2'd1, 1'b1}) begin
            errors++; $display("FAIL after_drain_grant got grant=%0d vld=%b want 1 1", a_grant, a_m_req_vld);
        end
        req_vld = '0; m_rsp_vld = 1'b1; m_rsp_mac = '0; rsp_rdy = 4'b1111;
        repeat (3) @(negedge clk);
        m_rsp_vld = 1'b0; rsp_rdy = '0;
    endtask

    task automatic test_race;
        @(negedge clk);
        req_vld = 4'b0100; m_req_rdy = 1'b1; m_rsp_vld = 1'b0; rsp_rdy = 4'b0100;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        repeat (15) @(negedge clk);
        checks++;
        if (a_s_rsp_vld !== 4'b0000) begin errors++; $display("FAIL race_early got vld=%b want 0000", a_s_rsp_vld); end
        m_rsp_vld = 1'b1; m_rsp_mac = 48'h0A0B0C0D0E0F; m_rsp_err = 1'b0;
        @(negedge clk);
        m_rsp_vld = 1'b0;
        checks++;
        if ({a_tev, a_s_rsp_vld, a_err, a_mac} !== {1'b0, 4'b0100, 1'b0, 48'h0A0B0C0D0E0F}) begin
            errors++; $display("FAIL race_resp got tev=%b vld=%b err=%b mac=%h want 0 0100 0 0a0b0c0d0e0f",
                               a_tev, a_s_rsp_vld, a_err, a_mac);
        end
        @(negedge clk);
        checks++;
        if ({a_busy, a_tev, a_m_rsp_rdy} !== 3'b000) begin
            errors++; $display("FAIL race_nodrain got busy=%b tev=%b rsp_rdy=%b want 0 0 0", a_busy, a_tev, a_m_rsp_rdy);
        end
        rsp_rdy = '0;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        req_vld = 4'b1000; m_req_rdy = 1'b1; m_rsp_vld = 1'b0; rsp_rdy = '0;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        m_rsp_vld = 1'b1; m_rsp_mac = 48'h112233445566; m_rsp_err = 1'b1;
        @(negedge clk);
        m_rsp_mac = 48'hFFFFFFFFFFFF; m_rsp_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({a_s_rsp_vld, a_err, a_mac} !== {4'b1000, 1'b1, 48'h112233445566}) begin
                errors++; $display("FAIL stall_hold[%0d] got vld=%b err=%b mac=%h want 1000 1 112233445566",
                                   i, a_s_rsp_vld, a_err, a_mac);
            end
            @(negedge clk);
        end
        rsp_rdy = 4'b1000; m_rsp_vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_s_rsp_vld, a_busy} !== 5'b0) begin
            errors++; $display("FAIL stall_release got vld=%b busy=%b want 0000 0", a_s_rsp_vld, a_busy);
        end
        rsp_rdy = '0;
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        req_vld = 4'b0010; m_req_rdy = 1'b1; m_rsp_vld = 1'b1; m_rsp_mac = 48'h5A5A5A5A5A5A; m_rsp_err = 1'b1;
        rsp_rdy = 4'b1111;
        @(negedge clk);
        req_vld = '0;
        repeat (3) @(negedge clk);
        m_rsp_vld = 1'b0; req_vld = 4'b0100;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        checks++;
        if ({a_m_rsp_rdy, a_grant} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL midwait_pre got rsp_rdy=%b grant=%0d want 1 2", a_m_rsp_rdy, a_grant);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_m_req_vld, a_m_rsp_rdy, a_tev, a_s_rsp_vld, a_grant, a_err, a_mac} !== 59'd0) begin
            errors++; $display("FAIL midwait_reset got busy=%b rsp_rdy=%b grant=%0d err=%b mac=%h want all 0",
                               a_busy, a_m_rsp_rdy, a_grant, a_err, a_mac);
        end
        @(negedge clk);
        rst_n = 1'b1; req_vld = 4'b1111;
        #1;
        checks++;
        if ({a_req_rdy, b_req_rdy} !== 8'b0001_0001) begin
            errors++; $display("FAIL post_reset_rdy got rr=%b fp=%b want 0001 0001", a_req_rdy, b_req_rdy);
        end
        @(negedge clk);
        checks++;
        if ({a_grant, a_m_req_vld} !== {2'd0, 1'b1}) begin
            errors++; $display("FAIL post_reset_grant got grant=%0d vld=%b want 0 1", a_grant, a_m_req_vld);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_race();
        test_backpressure();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arp_req_arb.md
Name: arp_req_arb

Overview:
- Shares the single ARP request/response channel of the ARP block among S_COUNT independent requesters, such as several IP TX engines or a management path.
- Grants one requester at a time and holds the grant until that requester's response has been handed back.
- A watchdog converts a lost response into an error response.
- Sits between the requesters and the ARP block's arp_request_*/arp_response_* ports.

Parameters:
- S_COUNT, 4, number of requesters (>=2).
- ARB_ROUND_ROBIN, 1, 1 = round-robin starting after the last granted index; 0 = fixed priority, lowest index wins.
- TIMEOUT_CYCLES, 125000000*32, cycles to wait for a response before a synthesised error. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arp_request_valid  in  S_COUNT  per-requester request valid
- s_arp_request_ready  out  S_COUNT  per-requester request accept
- s_arp_request_ip  in  32*S_COUNT  requester i IP at bits [32i+31:32i]
- s_arp_response_valid  out  S_COUNT  per-requester response valid
- s_arp_response_ready  in  S_COUNT  per-requester response accept
- s_arp_response_error  out  1  response error, shared, qualified by s_arp_response_valid
- s_arp_response_mac  out  48  response MAC, shared
- m_arp_request_valid  out  1  to ARP block
- m_arp_request_ready  in  1
- m_arp_request_ip  out  32
- m_arp_response_valid  in  1  from ARP block
- m_arp_response_ready  out  1
- m_arp_response_error  in  1
- m_arp_response_mac  in  48
- busy  out  1  high whenever state != IDLE or drain active
- grant_index  out  max(1,$clog2(S_COUNT))  index of current or last grant
- timeout_event  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset, asynchronous, active low:
  - state=IDLE, drain=0, counter=0, last_grant=S_COUNT-1, so index 0 wins first under round-robin.
  - All valid/ready outputs 0, mac/ip/error registers 0, grant_index=0, timeout_event=0.
  - Reset mid-transaction abandons the transaction silently.
- IDLE (drain=0):
  - If any s_arp_request_valid is high, select the winner per ARB_ROUND_ROBIN.
  - s_arp_request_ready is combinationally one-hot on the winner in that cycle.
  - On handshake: latch the IP into ip_reg, set grant, go to REQ.
  - No valid requests: stay in IDLE, all s_arp_request_ready=0.
- REQ:
  - m_arp_request_valid=1, m_arp_request_ip=ip_reg. This is registered, so first assertion is 1 cycle after the s handshake.
  - On m_arp_request_ready, go to WAIT and clear counter.
  - m_arp_request_ip stays stable while valid and ready are not both high.
- WAIT:
  - m_arp_response_ready=1 in this state only (except during drain).
  - On m_arp_response_valid: latch mac and error, go to RESP.
  - Otherwise counter increments. When counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0):
    - latch error=1, mac=0;
    - pulse timeout_event;
    - set drain=1;
    - go to RESP.
  - A response in the same cycle as expiry wins: it is delivered normally, with no timeout and no drain.
- RESP:
  - s_arp_response_valid is one-hot on the grant; s_arp_response_error and s_arp_response_mac come from the latched values.
  - On s_arp_response_ready[grant]: update last_grant=grant and go to IDLE.
  - Outputs hold stable until accepted. The requester may stall indefinitely.
- Drain (drain=1, state IDLE):
  - No new grants. m_arp_response_ready=1; one late response is discarded and clears drain.
  - The counter restarts on drain entry; if it expires again with no response, drain clears anyway.
- Round-robin:
  - Search order is last_grant+1 … S_COUNT-1, then 0 … last_grant, with wrap-around.
  - A requester holding valid continuously cannot starve the others.
- Widths:
  - Counter width is $clog2(TIMEOUT_CYCLES+1), saturating; it never wraps.
  - grant_index is registered and equals the grant from REQ through RESP.
- At most one outstanding ARP transaction. m_arp_request_valid and m_arp_response_ready are never high simultaneously.

Test Plan:
- Single request: req1 ip=0xC0A80102, ARP ready, response mac=0x001122334455 err=0 after 5 cycles -> m_arp_request_valid 1 cycle after accept with ip=0xC0A80102; s_arp_response_valid=4'b0010 with that mac; busy low afterwards.
- Contention, ARB_ROUND_ROBIN=1: all 4 requesters valid continuously, zero-latency ARP responses -> grant order 0,1,2,3,0.
- Contention, ARB_ROUND_ROBIN=0: same stimulus -> grant 0 repeatedly while req0 stays valid.
- Timeout, TIMEOUT_CYCLES=16: ARP never responds -> after 16 WAIT cycles timeout_event pulses; requester gets error=1, mac=0; a late response injected 3 cycles later is consumed with no s_arp_response_valid; next request is granted only after that.
- Race, TIMEOUT_CYCLES=16: response arrives exactly on cycle 16 of WAIT -> normal delivery, timeout_event stays 0, drain stays 0.
- Backpressure and reset: requester holds s_arp_response_ready=0 for 10 cycles -> mac/error/valid stable throughout. rst_n asserted mid-WAIT -> all outputs 0 immediately, next grant goes to index 0.
